// File: rtl/ms_timer_pkg.sv
// Shared definitions for the millisecond stopwatch: FSM encodings, BCD limit, default divider.
package ms_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_e;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam int         DEFAULT_DIV   = 100000;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit cascaded BCD counter (0000..9999); CARRY flags an increment that wraps 9999 to 0000.
module bcd_counter4
    import ms_timer_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        INC,
    input  logic        CLR,
    output logic [15:0] COUNT,
    output logic        CARRY
);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        carry_chain;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        count_d     = count_q;
        carry_chain = INC;
        for (int i = 0; i < 4; i++) begin
            if (carry_chain) begin
                if (count_q[4*i +: 4] == BCD_DIGIT_MAX) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry_chain       = 1'b0;
                end
            end
        end
        if (CLR) begin
            count_d = '0;
        end
        CARRY = carry_chain;
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;

endmodule

// File: rtl/ms_timer_ctrl.sv
// Millisecond stopwatch: IDLE/RUN/PAUSED FSM, DIV-cycle prescaler and BCD elapsed-time count.
// Define MS_TIMER_LAP_EN to enable lap capture; otherwise LAP is ignored and lap outputs read 0.
module ms_timer_ctrl
    import ms_timer_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV,
    parameter int PW  = 17
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        STOP,
    input  logic        CLEAR,
    input  logic        LAP,
    output logic        TICK,
    output logic [15:0] MS_BCD,
    output logic        OVF,
    output logic [1:0]  STATE,
    output logic [15:0] LAP_BCD,
    output logic        LAP_VALID
);

    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    state_e        state_q;
    logic [PW-1:0] pre_q;
    logic          tick_q;
    logic          ovf_q;
    logic          wrap;
    logic          carry;
    logic [15:0]   ms_bcd;

    // The prescaler keys off the current state, so STOP sampled on a wrap edge still ticks.
    assign wrap = (state_q == ST_RUN) && (pre_q == PRE_MAX);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (CLEAR) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            tick_q <= wrap;
            ovf_q  <= carry;
            case (state_q)
                ST_IDLE: begin
                    pre_q <= '0;
                    if (START) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    pre_q <= wrap ? '0 : pre_q + PW'(1);
                    if (STOP) state_q <= ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (START) state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_IDLE;
                    pre_q   <= '0;
                end
            endcase
        end
    end

    bcd_counter4 u_bcd (
        .CLK   (CLK),
        .RST   (RST),
        .INC   (wrap && !CLEAR),
        .CLR   (CLEAR),
        .COUNT (ms_bcd),
        .CARRY (carry)
    );

    assign TICK   = tick_q;
    assign OVF    = ovf_q;
    assign MS_BCD = ms_bcd;
    assign STATE  = state_q;

`ifdef MS_TIMER_LAP_EN
    logic [15:0] lap_q;
    logic        lap_valid_q;

    // The capture takes the count before this edge's increment.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else if (CLEAR) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else if (LAP && (state_q == ST_RUN || state_q == ST_PAUSED)) begin
            lap_q       <= ms_bcd;
            lap_valid_q <= 1'b1;
        end
    end

    assign LAP_BCD   = lap_q;
    assign LAP_VALID = lap_valid_q;
`else
    logic unused_lap;
    assign unused_lap = LAP;
    assign LAP_BCD    = '0;
    assign LAP_VALID  = 1'b0;
`endif

endmodule

// File: tb/tb_ms_timer_ctrl.sv
// Bench for ms_timer_ctrl: a DIV=10 and a DIV=2 instance share stimulus against an integer-level model.
module tb_ms_timer_ctrl;

`ifdef MS_TIMER_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic clear = 1'b0;
    logic lap   = 1'b0;

    logic        tick_o      [2];
    logic        ovf_o       [2];
    logic [15:0] ms_bcd_o    [2];
    logic [1:0]  state_o     [2];
    logic [15:0] lap_bcd_o   [2];
    logic        lap_valid_o [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    ms_timer_ctrl #(.DIV(10), .PW(4)) u_dut10 (
        .CLK(clk), .RST(rst_n), .START(start), .STOP(stop), .CLEAR(clear), .LAP(lap),
        .TICK(tick_o[0]), .MS_BCD(ms_bcd_o[0]), .OVF(ovf_o[0]), .STATE(state_o[0]),
        .LAP_BCD(lap_bcd_o[0]), .LAP_VALID(lap_valid_o[0])
    );

    ms_timer_ctrl #(.DIV(2), .PW(2)) u_dut2 (
        .CLK(clk), .RST(rst_n), .START(start), .STOP(stop), .CLEAR(clear), .LAP(lap),
        .TICK(tick_o[1]), .MS_BCD(ms_bcd_o[1]), .OVF(ovf_o[1]), .STATE(state_o[1]),
        .LAP_BCD(lap_bcd_o[1]), .LAP_VALID(lap_valid_o[1])
    );

    function automatic int div_of(input int k);
        return (k == 0) ? 10 : 2;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: elapsed milliseconds as a plain integer, run-cycle count since the last tick.
    int m_state [2];
    int m_pre   [2];
    int m_ms    [2];
    int m_lap   [2];
    bit m_tick  [2];
    bit m_ovf   [2];
    bit m_lapv  [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clear) begin
                m_state[k] = S_IDLE;
                m_pre[k]   = 0;
                m_ms[k]    = 0;
                m_lap[k]   = 0;
                m_tick[k]  = 1'b0;
                m_ovf[k]   = 1'b0;
                m_lapv[k]  = 1'b0;
            end else begin
                m_tick[k] = 1'b0;
                m_ovf[k]  = 1'b0;
                if (LAP_EN && lap && m_state[k] != S_IDLE) begin
                    m_lap[k]  = m_ms[k];
                    m_lapv[k] = 1'b1;
                end
                if (m_state[k] == S_RUN) begin
                    m_pre[k]++;
                    if (m_pre[k] == div_of(k)) begin
                        m_pre[k]  = 0;
                        m_tick[k] = 1'b1;
                        m_ms[k]   = (m_ms[k] + 1) % 10000;
                        m_ovf[k]  = (m_ms[k] == 0);
                    end
                    if (stop) m_state[k] = S_PAUSED;
                end else if (start) begin
                    m_state[k] = S_RUN;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("div%0d.state", div_of(k)), 32'(state_o[k]), 32'(m_state[k]));
                check($sformatf("div%0d.tick", div_of(k)), 32'(tick_o[k]), 32'(m_tick[k]));
                check($sformatf("div%0d.ovf", div_of(k)), 32'(ovf_o[k]), 32'(m_ovf[k]));
                check($sformatf("div%0d.ms_bcd", div_of(k)), 32'(ms_bcd_o[k]), 32'(to_bcd(m_ms[k])));
                check($sformatf("div%0d.lap_bcd", div_of(k)), 32'(lap_bcd_o[k]), 32'(to_bcd(m_lap[k])));
                check($sformatf("div%0d.lap_valid", div_of(k)), 32'(lap_valid_o[k]), 32'(m_lapv[k]));
            end
        end
    end

    task automatic pulse_cmd(input bit s, input bit p, input bit c, input bit l);
        start = s;
        stop  = p;
        clear = c;
        lap   = l;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        lap   = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  seen_tick;

        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset.state", 32'(state_o[0]), 32'h0);
        check("reset.ms_bcd", 32'(ms_bcd_o[0]), 32'h0);
        check("reset.tick", 32'(tick_o[0]), 32'h0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        // Run 35 cycles, pause 20, resume 5: DIV=10 instance shows 0004.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (34) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("pause.state", 32'(state_o[0]), 32'h2);
        seen_tick = 1'b0;
        repeat (19) begin
            @(negedge clk);
            if (tick_o[0] || tick_o[1]) seen_tick = 1'b1;
        end
        check("pause.no_tick", 32'(seen_tick), 32'h0);
        check("pause.ms_bcd", 32'(ms_bcd_o[0]), 32'h0003);
        pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("resume.ms_bcd", 32'(ms_bcd_o[0]), 32'h0004);
        check("resume.tick", 32'(tick_o[0]), 32'h1);

        // Simultaneous commands.
        pulse_cmd(1'b1, 1'b1, 1'b0, 1'b0);
        check("start_stop.state", 32'(state_o[0]), 32'h2);
        pulse_cmd(1'b1, 1'b0, 1'b1, 1'b0);
        check("clear_start.state", 32'(state_o[0]), 32'h0);
        check("clear_start.ms_bcd", 32'(ms_bcd_o[0]), 32'h0);
        check("clear_start.ms_bcd2", 32'(ms_bcd_o[1]), 32'h0);

        // Asynchronous reset mid-count, then START in the first cycle after release.
        pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        while (ms_bcd_o[0] != 16'h0042 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_0042", 32'(ms_bcd_o[0]), 32'h0042);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.ms_bcd", 32'(ms_bcd_o[0]), 32'h0);
        check("async_rst.state", 32'(state_o[0]), 32'h0);
        check("async_rst.tick_ovf", 32'({tick_o[0], ovf_o[0], tick_o[1], ovf_o[1]}), 32'h0);
        check("async_rst.ms_bcd2", 32'(ms_bcd_o[1]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst.state", 32'(state_o[0]), 32'h1);
        cnt = 0;
        while (!tick_o[0] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("first_tick_latency", 32'(cnt), 32'd10);

        // Lap: ignored in IDLE, captures pre-increment value while running.
        pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0);
        pulse_cmd(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_idle.valid", 32'(lap_valid_o[0]), 32'h0);
        pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        while (ms_bcd_o[0] != 16'h0123 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_0123", 32'(ms_bcd_o[0]), 32'h0123);
        pulse_cmd(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap.bcd", 32'(lap_bcd_o[0]), LAP_EN ? 32'h0123 : 32'h0);
        check("lap.valid", 32'(lap_valid_o[0]), LAP_EN ? 32'h1 : 32'h0);
        check("lap.state", 32'(state_o[0]), 32'h1);
        pulse_cmd(1'b0, 1'b0, 1'b1, 1'b1);
        check("clear_lap.valid", 32'(lap_valid_o[0]), 32'h0);

        // Wrap 9999 -> 0000 on the DIV=2 instance, then STOP on a wrap edge.
        pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        while (!ovf_o[1] && cnt < 25000) begin
            @(negedge clk);
            cnt++;
        end
        check("ovf.seen", 32'(ovf_o[1]), 32'h1);
        check("ovf.ms_bcd", 32'(ms_bcd_o[1]), 32'h0);
        check("ovf.tick", 32'(tick_o[1]), 32'h1);
        check("ovf.state", 32'(state_o[1]), 32'h1);
        stop = 1'b1;
        @(negedge clk);
        check("ovf.one_cycle", 32'(ovf_o[1]), 32'h0);
        check("div2.no_tick_odd", 32'(tick_o[1]), 32'h0);
        stop = 1'b0;
        // STOP was set one cycle early by design: sampled on the non-wrap edge for DIV=2.
        check("stop_nonwrap.state", 32'(state_o[1]), 32'h2);
        check("stop_nonwrap.ms_bcd", 32'(ms_bcd_o[1]), 32'h0);
        pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_wrap.state", 32'(state_o[1]), 32'h2);
        check("stop_wrap.tick", 32'(tick_o[1]), 32'h1);
        check("stop_wrap.ms_bcd", 32'(ms_bcd_o[1]), 32'h0001);
        repeat (4) @(negedge clk);
        check("stop_wrap.hold", 32'(ms_bcd_o[1]), 32'h0001);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
